// File: rtl/dmux_stream.sv
// dmux_stream: pipelined, handshaked demultiplexer.
// A single producer stream is routed through LATENCY register stages to one of
// OUTPUT_COUNT consumer lanes. The stall is global: a blocked head freezes
// every stage. Words whose select is out of range are consumed and dropped,
// and the drop is reported on err/err_count.
module dmux_stream #(
    parameter int WIDTH        = 8,
    parameter int OUTPUT_COUNT = 4,
    parameter int LATENCY      = 2,
    parameter int HOLD         = 0,
    parameter int ERR_WIDTH    = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [$clog2(OUTPUT_COUNT)-1:0]   sel,
    input  logic [WIDTH-1:0]                  in,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [WIDTH*OUTPUT_COUNT-1:0]     out,
    output logic [OUTPUT_COUNT-1:0]           out_valid,
    input  logic [OUTPUT_COUNT-1:0]           out_ready,
    output logic                              err,
    output logic [ERR_WIDTH-1:0]              err_count
);

    localparam int SW = $clog2(OUTPUT_COUNT);

    logic [LATENCY-1:0]                  r_vld;
    logic [LATENCY-1:0][SW-1:0]          r_sel;
    logic [LATENCY-1:0][WIDTH-1:0]       r_dat;
    logic [OUTPUT_COUNT-1:0][WIDTH-1:0]  r_hold;
    logic                                r_err;
    logic [ERR_WIDTH-1:0]                r_cnt;

    logic                                w_head_vld;
    logic [SW-1:0]                       w_head_sel;
    logic [WIDTH-1:0]                    w_head_dat;
    logic                                w_head_rdy;
    logic                                w_sel_ok;
    logic                                w_stall;
    logic                                w_acc;
    logic                                w_bad;

    assign w_head_vld = r_vld[LATENCY-1];
    assign w_head_sel = r_sel[LATENCY-1];
    assign w_head_dat = r_dat[LATENCY-1];

    // Select range check on the input, and ready of the lane the head targets.
    // Loop compares avoid indexing out_ready with a select wider than the lane count.
    always_comb begin
        w_sel_ok   = 1'b0;
        w_head_rdy = 1'b0;
        for (int k = 0; k < OUTPUT_COUNT; k++) begin
            if (sel == SW'(k)) begin
                w_sel_ok = 1'b1;
            end
            if (w_head_sel == SW'(k)) begin
                w_head_rdy = out_ready[k];
            end
        end
    end

    assign w_stall  = w_head_vld && !w_head_rdy;
    assign in_ready = !w_stall;
    assign w_acc    = in_valid && !w_stall;
    assign w_bad    = w_acc && !w_sel_ok;

    // Pipeline stages: shift towards the head unless the head is blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_sel <= '0;
            r_dat <= '0;
        end else if (!w_stall) begin
            r_vld[0] <= w_acc && w_sel_ok;
            r_sel[0] <= sel;
            r_dat[0] <= in;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_sel[i] <= r_sel[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    // Per-lane hold registers capture the last word transferred on that lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else begin
            for (int k = 0; k < OUTPUT_COUNT; k++) begin
                if (HOLD != 0 && out_valid[k] && out_ready[k]) begin
                    r_hold[k] <= w_head_dat;
                end
            end
        end
    end

    // Dropped-word pulse and saturating drop counter; independent of the stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_err <= w_bad;
            if (w_bad && r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign err       = r_err;
    assign err_count = r_cnt;

    // Lane outputs: the head word on its lane, idle lanes show zero or their hold value.
    always_comb begin
        out_valid = '0;
        out       = '0;
        for (int k = 0; k < OUTPUT_COUNT; k++) begin
            if (w_head_vld && w_head_sel == SW'(k)) begin
                out_valid[k]             = 1'b1;
                out[k*WIDTH +: WIDTH]    = w_head_dat;
            end else if (HOLD != 0) begin
                out[k*WIDTH +: WIDTH]    = r_hold[k];
            end
        end
    end

endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream. Five instances with different parameters share one
// stimulus stream; a per-word countdown scoreboard predicts every instance's
// outputs each cycle, while the scenario tasks check the directed cases.
module tb_dmux_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] s_sel;
    logic [7:0] s_in;
    logic       s_iv;
    logic [3:0] s_ordy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rdy0, rdy1, rdy2, rdy3, rdy4;
    logic [31:0] out0, out1, out3, out4;
    logic [23:0] out2;
    logic [3:0]  vld0, vld1, vld3, vld4;
    logic [2:0]  vld2;
    logic        err0, err1, err2, err3, err4;
    logic [15:0] cnt0, cnt1, cnt3, cnt4;
    logic [2:0]  cnt2;

    dmux_stream #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(2), .HOLD(0), .ERR_WIDTH(16)) u_d0 (
        .clk(clk), .rst_n(rst_n), .sel(s_sel), .in(s_in), .in_valid(s_iv), .in_ready(rdy0),
        .out(out0), .out_valid(vld0), .out_ready(s_ordy), .err(err0), .err_count(cnt0));
    dmux_stream #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(2), .HOLD(1), .ERR_WIDTH(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .sel(s_sel), .in(s_in), .in_valid(s_iv), .in_ready(rdy1),
        .out(out1), .out_valid(vld1), .out_ready(s_ordy), .err(err1), .err_count(cnt1));
    dmux_stream #(.WIDTH(8), .OUTPUT_COUNT(3), .LATENCY(2), .HOLD(0), .ERR_WIDTH(3)) u_d2 (
        .clk(clk), .rst_n(rst_n), .sel(s_sel), .in(s_in), .in_valid(s_iv), .in_ready(rdy2),
        .out(out2), .out_valid(vld2), .out_ready(s_ordy[2:0]), .err(err2), .err_count(cnt2));
    dmux_stream #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(1), .HOLD(0), .ERR_WIDTH(16)) u_d3 (
        .clk(clk), .rst_n(rst_n), .sel(s_sel), .in(s_in), .in_valid(s_iv), .in_ready(rdy3),
        .out(out3), .out_valid(vld3), .out_ready(s_ordy), .err(err3), .err_count(cnt3));
    dmux_stream #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(8), .HOLD(1), .ERR_WIDTH(16)) u_d4 (
        .clk(clk), .rst_n(rst_n), .sel(s_sel), .in(s_in), .in_valid(s_iv), .in_ready(rdy4),
        .out(out4), .out_valid(vld4), .out_ready(s_ordy), .err(err4), .err_count(cnt4));

    logic        o_rdy [5];
    logic [31:0] o_out [5];
    logic [3:0]  o_vld [5];
    logic        o_err [5];
    logic [15:0] o_cnt [5];

    assign o_rdy[0] = rdy0;  assign o_out[0] = out0;  assign o_vld[0] = vld0;
    assign o_rdy[1] = rdy1;  assign o_out[1] = out1;  assign o_vld[1] = vld1;
    assign o_rdy[2] = rdy2;  assign o_out[2] = {8'h00, out2};  assign o_vld[2] = {1'b0, vld2};
    assign o_rdy[3] = rdy3;  assign o_out[3] = out3;  assign o_vld[3] = vld3;
    assign o_rdy[4] = rdy4;  assign o_out[4] = out4;  assign o_vld[4] = vld4;
    assign o_err[0] = err0;  assign o_cnt[0] = cnt0;
    assign o_err[1] = err1;  assign o_cnt[1] = cnt1;
    assign o_err[2] = err2;  assign o_cnt[2] = {13'h0, cnt2};
    assign o_err[3] = err3;  assign o_cnt[3] = cnt3;
    assign o_err[4] = err4;  assign o_cnt[4] = cnt4;

    function automatic int p_n(input int d);
        return (d == 2) ? 3 : 4;
    endfunction
    function automatic int p_l(input int d);
        return (d == 3) ? 1 : ((d == 4) ? 8 : 2);
    endfunction
    function automatic bit p_h(input int d);
        return (d == 1 || d == 4);
    endfunction
    function automatic int p_max(input int d);
        return (d == 2) ? 7 : 65535;
    endfunction

    // Reference model: the words in flight in acceptance order, each with the
    // number of unstalled cycles still needed before it is presented.
    int         m_n    [5];
    logic [1:0] m_sel  [5][16];
    logic [7:0] m_dat  [5][16];
    int         m_left [5][16];
    logic [7:0] m_hold [5][4];
    logic       m_err  [5];
    int         m_cnt  [5];

    always @(negedge clk) begin : monitor
        logic       head;
        logic       stall;
        logic       acc;
        logic       bad;
        logic [1:0] hs;
        logic [3:0] ev;
        logic [7:0] el;
        for (int d = 0; d < 5; d++) begin
            if (!rst_n) begin
                checks++;
                if (o_vld[d] !== 4'b0 || o_out[d] !== 32'h0 || o_rdy[d] !== 1'b1 ||
                    o_err[d] !== 1'b0 || o_cnt[d] !== 16'h0) begin
                    failures++;
                    $display("FAIL mon_reset dut%0d: vld=%b out=%h rdy=%b err=%b cnt=%0d, want all zero with rdy=1",
                             d, o_vld[d], o_out[d], o_rdy[d], o_err[d], o_cnt[d]);
                end
                m_n[d]   = 0;
                m_err[d] = 1'b0;
                m_cnt[d] = 0;
                for (int k = 0; k < 4; k++) m_hold[d][k] = 8'h00;
            end else begin
                head  = (m_n[d] > 0) && (m_left[d][0] == 0);
                hs    = m_sel[d][0];
                stall = head && !s_ordy[hs];
                ev    = 4'b0;
                if (head) ev[hs] = 1'b1;
                checks++;
                if (o_rdy[d] !== !stall) begin
                    failures++;
                    $display("FAIL mon_in_ready dut%0d cyc%0d: got %b want %b", d, cyc, o_rdy[d], !stall);
                end
                checks++;
                if (o_vld[d] !== ev) begin
                    failures++;
                    $display("FAIL mon_out_valid dut%0d cyc%0d: got %b want %b", d, cyc, o_vld[d], ev);
                end
                checks++;
                if (o_err[d] !== m_err[d] || o_cnt[d] !== 16'(m_cnt[d])) begin
                    failures++;
                    $display("FAIL mon_err dut%0d cyc%0d: got err=%b cnt=%0d want err=%b cnt=%0d",
                             d, cyc, o_err[d], o_cnt[d], m_err[d], m_cnt[d]);
                end
                for (int k = 0; k < p_n(d); k++) begin
                    if (head && int'(hs) == k) el = m_dat[d][0];
                    else if (p_h(d))          el = m_hold[d][k];
                    else                      el = 8'h00;
                    checks++;
                    if (o_out[d][k*8 +: 8] !== el) begin
                        failures++;
                        $display("FAIL mon_lane dut%0d lane%0d cyc%0d: got %h want %h",
                                 d, k, cyc, o_out[d][k*8 +: 8], el);
                    end
                end
                acc = s_iv && !stall;
                bad = acc && (int'(s_sel) >= p_n(d));
                if (!stall) begin
                    if (head) begin
                        if (p_h(d)) m_hold[d][hs] = m_dat[d][0];
                        for (int i = 0; i < m_n[d] - 1; i++) begin
                            m_sel[d][i]  = m_sel[d][i+1];
                            m_dat[d][i]  = m_dat[d][i+1];
                            m_left[d][i] = m_left[d][i+1];
                        end
                        m_n[d]--;
                    end
                    for (int i = 0; i < m_n[d]; i++) m_left[d][i]--;
                    if (acc && !bad) begin
                        m_sel[d][m_n[d]]  = s_sel;
                        m_dat[d][m_n[d]]  = s_in;
                        m_left[d][m_n[d]] = p_l(d) - 1;
                        m_n[d]++;
                    end
                end
                m_err[d] = bad;
                if (bad && m_cnt[d] < p_max(d)) m_cnt[d]++;
            end
        end
    end

    task automatic drive(input logic iv, input logic [1:0] sl, input logic [7:0] dt, input logic [3:0] ordy);
        @(posedge clk);
        #1;
        s_iv   = iv;
        s_sel  = sl;
        s_in   = dt;
        s_ordy = ordy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 2'd0, 8'h00, 4'hF);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        s_iv   = 1'b0;
        s_sel  = 2'd0;
        s_in   = 8'h00;
        s_ordy = 4'hF;
        repeat (2) @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1 || vld0 !== 4'b0 || out0 !== 32'h0 || err0 !== 1'b0 || cnt0 !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b vld=%b out=%h err=%b cnt=%0d, want 1/0/0/0/0",
                     rdy0, vld0, out0, err0, cnt0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy1 !== 1'b1 || vld1 !== 4'b0 || out1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_release: rdy=%b vld=%b out=%h, want 1/0/0", rdy1, vld1, out1);
        end
    endtask

    task automatic test_free_flow();
        logic [3:0]  ev;
        logic [31:0] eo;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive(1'b1, 2'(c), 8'(8'h11 * (c + 1)), 4'hF);
            else       drive(1'b0, 2'd0, 8'h00, 4'hF);
            @(negedge clk);
            ev = 4'b0;
            eo = 32'h0;
            if (c >= 2 && c <= 5) begin
                ev[c-2]          = 1'b1;
                eo[(c-2)*8 +: 8] = 8'(8'h11 * (c - 1));
            end
            checks++;
            if (rdy0 !== 1'b1 || vld0 !== ev || out0 !== eo) begin
                failures++;
                $display("FAIL free_flow c%0d: rdy=%b vld=%b out=%h want rdy=1 vld=%b out=%h",
                         c, rdy0, vld0, out0, ev, eo);
            end
        end
        checks++;
        if (out1 !== 32'h44332211) begin
            failures++;
            $display("FAIL free_flow_hold: got %h want 44332211", out1);
        end
    endtask

    task automatic test_backpressure();
        logic        er;
        logic [3:0]  ev;
        logic [31:0] eo;
        for (int c = 0; c < 9; c++) begin
            case (c)
                0:       drive(1'b1, 2'd1, 8'hA5, 4'b1101);
                1:       drive(1'b1, 2'd0, 8'h01, 4'b1101);
                2, 3, 4: drive(1'b1, 2'd2, 8'h02, 4'b1101);
                5:       drive(1'b1, 2'd2, 8'h02, 4'b1111);
                default: drive(1'b0, 2'd0, 8'h00, 4'b1111);
            endcase
            @(negedge clk);
            er = !(c >= 2 && c <= 4);
            ev = 4'b0;
            eo = 32'h0;
            if (c >= 2 && c <= 5) begin ev = 4'b0010; eo = 32'h0000A500; end
            if (c == 6)           begin ev = 4'b0001; eo = 32'h00000001; end
            if (c == 7)           begin ev = 4'b0100; eo = 32'h00020000; end
            checks++;
            if (rdy0 !== er || vld0 !== ev || out0 !== eo) begin
                failures++;
                $display("FAIL backpressure c%0d: rdy=%b vld=%b out=%h want rdy=%b vld=%b out=%h",
                         c, rdy0, vld0, out0, er, ev, eo);
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 2'd2, 8'h5A, 4'hF);
        drive(1'b1, 2'd0, 8'h3C, 4'hF);
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        @(negedge clk);
        checks++;
        if (vld1 !== 4'b0001 || out1 !== 32'h445AA53C) begin
            failures++;
            $display("FAIL hold_lanes: vld=%b out=%h want vld=0001 out=445aa53c", vld1, out1);
        end
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        @(negedge clk);
        checks++;
        if (out1 !== 32'h445AA53C || out0 !== 32'h0) begin
            failures++;
            $display("FAIL hold_idle: hold=%h zero=%h want 445aa53c and 0", out1, out0);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out1 !== 32'h0 || vld1 !== 4'b0) begin
            failures++;
            $display("FAIL hold_reset: out=%h vld=%b want 0", out1, vld1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_bad_sel();
        drive(1'b1, 2'd3, 8'hEE, 4'hF);
        @(negedge clk);
        checks++;
        if (err2 !== 1'b0 || cnt2 !== 3'd0) begin
            failures++;
            $display("FAIL bad_sel_c0: err=%b cnt=%0d want 0/0", err2, cnt2);
        end
        drive(1'b1, 2'd0, 8'h77, 4'hF);
        @(negedge clk);
        checks++;
        if (err2 !== 1'b1 || cnt2 !== 3'd1) begin
            failures++;
            $display("FAIL bad_sel_pulse: err=%b cnt=%0d want 1/1", err2, cnt2);
        end
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        @(negedge clk);
        checks++;
        if (err2 !== 1'b0 || cnt2 !== 3'd1 || vld2 !== 3'b000) begin
            failures++;
            $display("FAIL bad_sel_drop: err=%b cnt=%0d vld=%b want 0/1/000", err2, cnt2, vld2);
        end
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        @(negedge clk);
        checks++;
        if (vld2 !== 3'b001 || out2 !== 24'h000077) begin
            failures++;
            $display("FAIL bad_sel_next: vld=%b out=%h want 001/000077", vld2, out2);
        end
        for (int i = 0; i < 8; i++) drive(1'b1, 2'd3, 8'(i), 4'hF);
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        @(negedge clk);
        checks++;
        if (err2 !== 1'b1 || cnt2 !== 3'd7) begin
            failures++;
            $display("FAIL bad_sel_saturate: err=%b cnt=%0d want 1/7", err2, cnt2);
        end
        idle(4);
        checks++;
        if (err2 !== 1'b0 || cnt2 !== 3'd7) begin
            failures++;
            $display("FAIL bad_sel_hold: err=%b cnt=%0d want 0/7", err2, cnt2);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 2'd1, 8'h61, 4'b1101);
        drive(1'b1, 2'd1, 8'h62, 4'b1101);
        drive(1'b0, 2'd0, 8'h00, 4'b1101);
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b0 || vld0 !== 4'b0010 || out0 !== 32'h00006100) begin
            failures++;
            $display("FAIL reset_mid_stall: rdy=%b vld=%b out=%h want 0/0010/00006100", rdy0, vld0, out0);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (rdy0 !== 1'b1 || vld0 !== 4'b0 || out0 !== 32'h0 || vld4 !== 4'b0 || out1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_async: rdy=%b vld=%b out=%h vld4=%b out1=%h want 1/0/0/0/0",
                     rdy0, vld0, out0, vld4, out1);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        s_ordy = 4'hF;
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 2'd0, 8'h00, 4'hF);
            @(negedge clk);
            checks++;
            if ((vld0 | vld1 | vld3 | vld4) !== 4'b0 || vld2 !== 3'b0) begin
                failures++;
                $display("FAIL reset_mid_nodeliver c%0d: vld0=%b vld4=%b want 0", c, vld0, vld4);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] ordy;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) ordy[k] = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), ordy);
        end
        idle(20);
        for (int d = 0; d < 5; d++) begin
            checks++;
            if (o_vld[d] !== 4'b0 || o_rdy[d] !== 1'b1) begin
                failures++;
                $display("FAIL random_drain dut%0d: vld=%b rdy=%b want 0/1", d, o_vld[d], o_rdy[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_flow();
        idle(3);
        test_backpressure();
        idle(3);
        test_hold();
        idle(2);
        test_bad_sel();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
